tug_rope_core: RTL and testbench

Parametrised game core for the tug-of-war board. It replaces the fixed 7-LED round/scorer path with one block that has a configurable rope length and a pseudo-random "get ready" delay. It also adds false-start penalties, tie handling and a latched match winner. It sits between the debounced push-button synchronisers and the LED/audio drivers, running on the divided game clock.

---
 rtl/tug_rope_core.sv | 191 +++++++++++++++++++
 tb/tb_tug_rope_core.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tug_rope_core.sv
// tug_rope_core
// Game core for the tug-of-war board. It runs a pseudo-random "get ready"
// delay (CLEAR), then an armed window (ARMED) in which the first button edge
// decides the round. Presses during CLEAR are false starts and reward the
// opponent. Reaching either end of the rope latches the match winner (DONE).
//
// Ports:
//   clk          game clock (divided clock)
//   rst          synchronous active-high reset
//   pbl, pbr     debounced left/right button levels, synchronous to clk
//   leds_out     rope display, one-hot at pos outside CLEAR, else all zero
//   pos          rope position, 0 = left end, LEDS-1 = right end
//   round_active high while ARMED
//   round_pulse  one-cycle strobe on each round resolution
//   last_result  00 none, 01 left, 10 right, 11 tie (held)
//   false_start  high with round_pulse when the resolution came from CLEAR
//   winner       00 none, 01 left, 10 right (latched until rst)
module tug_rope_core #(
  parameter int LEDS      = 7,
  parameter int DELAY_W   = 8,
  parameter int MIN_DELAY = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pbl,
  input  logic                     pbr,
  output logic [LEDS-1:0]          leds_out,
  output logic [$clog2(LEDS)-1:0]  pos,
  output logic                     round_active,
  output logic                     round_pulse,
  output logic [1:0]               last_result,
  output logic                     false_start,
  output logic [1:0]               winner
);

  localparam int POS_W = $clog2(LEDS);
  localparam int CNT_W = DELAY_W + 1;
  localparam logic [POS_W-1:0] CENTRE    = POS_W'((LEDS - 1) / 2);
  localparam logic [POS_W-1:0] RIGHT_END = POS_W'(LEDS - 1);
  localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_DELAY);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_pblQ;
  logic               r_pbrQ;
  logic [DELAY_W-1:0] r_lfsr;
  logic [CNT_W-1:0]   r_cnt;
  logic [POS_W-1:0]   r_pos;
  logic               r_roundPulse;
  logic [1:0]         r_lastResult;
  logic               r_falseStart;
  logic [1:0]         r_winner;

  logic               w_eL;
  logic               w_eR;
  logic               w_tie;
  logic               w_resolve;
  logic [POS_W-1:0]   w_newPos;
  logic [1:0]         w_result;
  logic               w_reachLeft;
  logic               w_reachRight;
  logic               w_fb;

  // Button _q registers reset to 1, so a button held through reset gives no edge.
  assign w_eL      = pbl & ~r_pblQ;
  assign w_eR      = pbr & ~r_pbrQ;
  assign w_tie     = w_eL & w_eR;
  assign w_resolve = (w_eL | w_eR) & (r_state != S_DONE);

  // Fibonacci feedback taps for the two supported LFSR widths.
  if (DELAY_W == 16) begin : g_tap16
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  end else begin : g_tap8
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  end

  // Round outcome. In CLEAR a press rewards the opponent. pos is always
  // strictly inside the rope outside DONE, so +/-1 cannot leave the range.
  always_comb begin
    w_newPos = r_pos;
    w_result = 2'b00;
    if (w_tie) begin
      w_result = 2'b11;
    end else if (w_eL) begin
      if (r_state == S_ARMED) begin
        w_newPos = r_pos - POS_W'(1);
        w_result = 2'b01;
      end else begin
        w_newPos = r_pos + POS_W'(1);
        w_result = 2'b10;
      end
    end else if (w_eR) begin
      if (r_state == S_ARMED) begin
        w_newPos = r_pos + POS_W'(1);
        w_result = 2'b10;
      end else begin
        w_newPos = r_pos - POS_W'(1);
        w_result = 2'b01;
      end
    end
  end

  assign w_reachLeft  = (w_newPos == '0);
  assign w_reachRight = (w_newPos == RIGHT_END);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state. A press in the cycle the counter hits zero still counts as CLEAR.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_CLEAR: begin
        if (w_resolve) begin
          w_nextState = (w_reachLeft || w_reachRight) ? S_DONE : S_CLEAR;
        end else if (r_cnt == '0) begin
          w_nextState = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_resolve) begin
          w_nextState = (w_reachLeft || w_reachRight) ? S_DONE : S_CLEAR;
        end
      end
      S_DONE:  w_nextState = S_DONE;
      default: w_nextState = S_CLEAR;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    round_active = (r_state == S_ARMED);
    leds_out     = '0;
    if (r_state != S_CLEAR) begin
      leds_out = LEDS'(1) << r_pos;
    end
  end

  // Datapath: edge history, LFSR, delay counter and the round/match results.
  // The counter reload uses the LFSR value seen in the resolving cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pblQ       <= 1'b1;
      r_pbrQ       <= 1'b1;
      r_lfsr       <= DELAY_W'(1);
      r_cnt        <= MIN_CNT + CNT_W'(1);
      r_pos        <= CENTRE;
      r_roundPulse <= 1'b0;
      r_lastResult <= 2'b00;
      r_falseStart <= 1'b0;
      r_winner     <= 2'b00;
    end else begin
      r_pblQ       <= pbl;
      r_pbrQ       <= pbr;
      r_lfsr       <= {r_lfsr[DELAY_W-2:0], w_fb};
      r_roundPulse <= w_resolve;
      r_falseStart <= w_resolve && (r_state == S_CLEAR);
      if (w_resolve) begin
        r_pos        <= w_newPos;
        r_lastResult <= w_result;
        r_cnt        <= MIN_CNT + {1'b0, r_lfsr};
        if (w_reachLeft) begin
          r_winner <= 2'b01;
        end else if (w_reachRight) begin
          r_winner <= 2'b10;
        end
      end else if ((r_state == S_CLEAR) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign pos         = r_pos;
  assign round_pulse = r_roundPulse;
  assign last_result = r_lastResult;
  assign false_start = r_falseStart;
  assign winner      = r_winner;

endmodule

// File: tb/tb_tug_rope_core.sv
// tb_tug_rope_core
// Self-checking bench for tug_rope_core. A behavioural model tracks the game
// as rope position, remaining CLEAR cycles and match status, and every cycle
// all outputs are compared against it. A second instance (LEDS=9,
// DELAY_W=16) shares the inputs and is checked after each reset.
module tb_tug_rope_core;

  localparam int LEDS      = 7;
  localparam int MIN_DELAY = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pbl = 1'b0;
  logic       pbr = 1'b0;
  logic [6:0] leds_out;
  logic [2:0] pos;
  logic       round_active;
  logic       round_pulse;
  logic [1:0] last_result;
  logic       false_start;
  logic [1:0] winner;

  logic [8:0] ledsB;
  logic [3:0] posB;
  logic       activeB;
  logic       pulseB;
  logic [1:0] lastB;
  logic       fsB;
  logic [1:0] winnerB;

  int total = 0;
  int bad   = 0;

  int mPos;
  int mWinner;
  int mLast;
  int mClearLeft;
  int mLfsr;
  bit mArmed;
  bit mDone;
  bit mPulse;
  bit mFs;
  bit mPrevL;
  bit mPrevR;

  tug_rope_core #(.LEDS(7), .DELAY_W(8), .MIN_DELAY(16)) dut (
    .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr),
    .leds_out(leds_out), .pos(pos), .round_active(round_active),
    .round_pulse(round_pulse), .last_result(last_result),
    .false_start(false_start), .winner(winner)
  );

  tug_rope_core #(.LEDS(9), .DELAY_W(16), .MIN_DELAY(16)) dutB (
    .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr),
    .leds_out(ledsB), .pos(posB), .round_active(activeB),
    .round_pulse(pulseB), .last_result(lastB),
    .false_start(fsB), .winner(winnerB)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Next value of the 8-bit LFSR: shift left, feed in parity of taps 8,6,5,4.
  function automatic int lfsrNext8(input int v);
    int fb;
    fb = $countones(v & 32'hB8) & 1;
    return ((v << 1) | fb) & 32'hFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Game rules at the level of rounds: who gains, how long CLEAR lasts.
  task automatic modelStep(input bit r, input bit l, input bit rr);
    bit eL;
    bit eR;
    int delta;
    if (r) begin
      mPos       = (LEDS - 1) / 2;
      mWinner    = 0;
      mLast      = 0;
      mPulse     = 0;
      mFs        = 0;
      mArmed     = 0;
      mDone      = 0;
      mLfsr      = 1;
      mClearLeft = MIN_DELAY + 1 + 1;
      mPrevL     = 1;
      mPrevR     = 1;
    end else begin
      eL     = l && !mPrevL;
      eR     = rr && !mPrevR;
      mPulse = 0;
      mFs    = 0;
      if (!mDone && (eL || eR)) begin
        if (eL && eR)   delta = 0;
        else if (mArmed) delta = eR ? 1 : -1;
        else             delta = eL ? 1 : -1;
        mLast  = (eL && eR) ? 3 : ((delta > 0) ? 2 : 1);
        mPos   = mPos + delta;
        mPulse = 1;
        mFs    = !mArmed;
        mArmed = 0;
        if (mPos == 0) begin
          mWinner = 1;
          mDone   = 1;
        end else if (mPos == LEDS - 1) begin
          mWinner = 2;
          mDone   = 1;
        end else begin
          mClearLeft = MIN_DELAY + mLfsr + 1;
        end
      end else if (!mDone && !mArmed) begin
        mClearLeft--;
        if (mClearLeft == 0) mArmed = 1;
      end
      mLfsr  = lfsrNext8(mLfsr);
      mPrevL = l;
      mPrevR = rr;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit l, input bit rr);
    @(negedge clk);
    rst = r;
    pbl = l;
    pbr = rr;
    modelStep(r, l, rr);
    @(posedge clk);
    #1;
    checkOutput("pos", 32'(pos), 32'(mPos));
    checkOutput("leds_out", 32'(leds_out), (mArmed || mDone) ? (32'd1 << mPos) : 32'd0);
    checkOutput("round_active", 32'(round_active), 32'(mArmed));
    checkOutput("round_pulse", 32'(round_pulse), 32'(mPulse));
    checkOutput("last_result", 32'(last_result), 32'(mLast));
    checkOutput("false_start", 32'(false_start), 32'(mFs));
    checkOutput("winner", 32'(winner), 32'(mWinner));
    if (r) begin
      checkOutput("B_pos", 32'(posB), 32'd4);
      checkOutput("B_leds", 32'(ledsB), 32'd0);
      checkOutput("B_active", 32'(activeB), 32'd0);
      checkOutput("B_winner", 32'(winnerB), 32'd0);
    end
  endtask

  task automatic waitArmed();
    int n;
    n = 0;
    while (!round_active && n < 600) begin
      applyStimulus(1'b0, pbl, pbr);
      n++;
    end
    checkOutput("armed_timeout", 32'(round_active), 32'd1);
  endtask

  initial begin
    int len;
    bit l;
    bit rr;
    bit r;
    $display("[TB] start");

    // Reset and first CLEAR length: MIN_DELAY + seed + 1 cycles.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    len = 1;
    while (!round_active && len < 600) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (!round_active) len++;
    end
    checkOutput("clear_len", 32'(len), 32'(MIN_DELAY + 2));

    // Fair left win, then a false start from CLEAR held through ARMED.
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitArmed();
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Tie while ARMED, then tie in CLEAR.
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Press exactly in the cycle the counter reaches zero: still a false start.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (MIN_DELAY + 1) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Button held through reset is not a press.
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Three fair left wins reach DONE; later presses change nothing.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      waitArmed();
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, i[0], i[1]);

    // Reset while ARMED at pos 5.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      waitArmed();
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    waitArmed();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Random play with occasional resets.
    l  = 0;
    rr = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) l = !l;
      if ($urandom_range(0, 29) == 0) rr = !rr;
      if (($urandom_range(0, 15) == 0) && l && !rr) rr = 1;
      r = ($urandom_range(0, 499) == 0) || (mDone && ($urandom_range(0, 59) == 0));
      applyStimulus(r, l, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
